cacheline_burst_adaptor: RTL and testbench

Responder on the physical-memory side of the L2 cache line interface. It accepts a 256-bit line read or write (pmem_* handshake: request held until a one-cycle resp) and converts it into a 4-beat, 64-bit burst transaction on the DRAM/burst memory port. Sits between cacheL2's pmem port and the burst memory model; it is the responder for the cache's initiator.

---
 rtl/cache_types.sv | 29 ++
 rtl/cacheline_burst_adaptor.sv | 143 ++++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared types for the L2 physical-memory side adaptor.
// Holds the line/beat geometry, the adaptor FSM state encoding and a
// helper that forces an address onto a cache-line boundary.
package cache_types;

    localparam int s_offset  = 5;
    localparam int s_line    = 256;
    localparam int s_beat    = 64;
    localparam int num_beats = s_line / s_beat;
    localparam int count_w   = $clog2(num_beats);

    typedef logic [s_line-1:0]  line_t;
    typedef logic [s_beat-1:0]  beat_t;
    typedef logic [count_w-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST,
        DONE
    } state_t;

    // Burst memory always transfers whole lines, so the low offset bits
    // of the request address carry no meaning on the burst side.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:s_offset], {s_offset{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor
// Responder for the L2 cache pmem port. A held line read/write request is
// turned into a 4-beat, 64-bit burst on the memory port; a single-cycle
// line_resp closes the request.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset (0 = reset)
//   line_address   line request address from the cache
//   line_wdata     256-bit write line from the cache
//   line_read      line read request, held until line_resp
//   line_write     line write request, held until line_resp
//   line_rdata     assembled read line, valid with line_resp
//   line_resp      one-cycle completion pulse
//   burst_address  line-aligned burst address, stable for the whole burst
//   burst_wdata    current write beat
//   burst_rdata    current read beat from memory
//   burst_read     burst read request
//   burst_write    burst write request
//   burst_resp     per-beat handshake from memory
module cacheline_burst_adaptor
    import cache_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  line_address,
    input  logic [255:0] line_wdata,
    input  logic         line_read,
    input  logic         line_write,
    output logic [255:0] line_rdata,
    output logic         line_resp,
    output logic [31:0]  burst_address,
    output logic [63:0]  burst_wdata,
    input  logic [63:0]  burst_rdata,
    output logic         burst_read,
    output logic         burst_write,
    input  logic         burst_resp
);

    state_t      state;
    state_t      next_state;
    logic [31:0] addr_q;
    line_t       wline_q;
    line_t       rbuf_q;
    count_t      count_q;
    logic        last_beat;

    assign last_beat  = (count_q == count_t'(num_beats - 1));
    assign line_rdata = rbuf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory-side outputs are decoded from the state and latched request
    // only, so a change on the line side mid-burst never reaches memory.
    // DONE always returns to IDLE, which keeps a request still held during
    // the response cycle from starting a second burst.
    always_comb begin
        next_state    = state;
        line_resp     = 1'b0;
        burst_read    = 1'b0;
        burst_write   = 1'b0;
        burst_address = 32'd0;
        burst_wdata   = '0;
        case (state)
            IDLE: begin
                if (line_write) begin
                    next_state = WR_BURST;
                end else if (line_read) begin
                    next_state = RD_BURST;
                end
            end
            WR_BURST: begin
                burst_write   = 1'b1;
                burst_address = line_align(addr_q);
                burst_wdata   = wline_q[s_beat*int'(count_q) +: s_beat];
                if (burst_resp && last_beat) begin
                    next_state = DONE;
                end
            end
            RD_BURST: begin
                burst_read    = 1'b1;
                burst_address = line_align(addr_q);
                if (burst_resp && last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                line_resp  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, beat counter and read line assembly. The counter
    // rolls from the last beat back to zero, which is exactly the start
    // value the next request needs; it is also cleared on accept.
    // The read buffer is only written by read beats, so line_rdata keeps
    // showing the most recent read line across later writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 32'd0;
            wline_q <= '0;
            rbuf_q  <= '0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write) begin
                        addr_q  <= line_address;
                        wline_q <= line_wdata;
                        count_q <= '0;
                    end else if (line_read) begin
                        addr_q  <= line_address;
                        count_q <= '0;
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        count_q <= count_q + count_t'(1);
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        rbuf_q[s_beat*int'(count_q) +: s_beat] <= burst_rdata;
                        count_q <= count_q + count_t'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Testbench for cacheline_burst_adaptor.
// The bench plays both sides: it presents line requests as the cache would
// and acts as a burst memory with configurable response gaps. Expected
// values come from the line-level behaviour: aligned address, four beats
// low-to-high, one response, and a latency of six cycles plus stalls.
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic         line_read;
    logic         line_write;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_read;
    logic         burst_write;
    logic         burst_resp;

    int checks = 0;
    int errors = 0;

    cacheline_burst_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // One line transaction with the bench acting as burst memory.
    // mode 0: respond every cycle, 1: two idle cycles between beats,
    // 2: random 0..3 idle cycles between beats.
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [255:0] wdata, input logic [255:0] rline,
                          input int mode, input bit hold,
                          output logic [255:0] wr_line, output int nw, output int nr,
                          output int resps, output int cycles, output int stalls,
                          output int addr_bad, output int gap_drop,
                          output int post_activity, output logic [255:0] got_rdata,
                          output bit timed_out);
        logic [31:0] exp_addr;
        int  wait_left;
        bit  started;
        bit  done;
        exp_addr = {addr[31:5], 5'b0};
        nw = 0; nr = 0; resps = 0; cycles = 0; stalls = 0; addr_bad = 0;
        gap_drop = 0; post_activity = 0; wr_line = '0; got_rdata = '0;
        timed_out = 1'b1; wait_left = 0; started = 1'b0; done = 1'b0;
        @(negedge clk);
        line_address = addr;
        line_wdata   = wdata;
        line_write   = wr;
        line_read    = rd;
        burst_resp   = 1'b0;
        for (int k = 1; k <= 400 && !done; k++) begin
            @(negedge clk);
            burst_resp  = 1'b0;
            burst_rdata = {$urandom, $urandom};
            if (line_resp) begin
                resps++;
                got_rdata = line_rdata;
                cycles    = k + 1;
                done      = 1'b1;
                timed_out = 1'b0;
                if (!hold) begin
                    line_read  = 1'b0;
                    line_write = 1'b0;
                end
            end else if (burst_read || burst_write) begin
                started = 1'b1;
                if (burst_address !== exp_addr) addr_bad++;
                if (wait_left > 0) begin
                    wait_left--;
                    stalls++;
                end else begin
                    burst_resp = 1'b1;
                    if (burst_write) begin
                        if (nw < 4) wr_line[64*nw +: 64] = burst_wdata;
                        nw++;
                    end
                    if (burst_read) begin
                        if (nr < 4) burst_rdata = rline[64*nr +: 64];
                        nr++;
                    end
                    wait_left = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
                end
            end else if (started) begin
                gap_drop++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            burst_resp = 1'b0;
            if (burst_read || burst_write || line_resp) post_activity++;
            line_read  = 1'b0;
            line_write = 1'b0;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b0;
        line_read = 1'b0; line_write = 1'b0; burst_resp = 1'b0;
        line_address = 32'h0; line_wdata = '0; burst_rdata = '0;
        #1;
        checks++;
        if ({line_resp, burst_read, burst_write} !== 3'b000 || burst_address !== 32'h0 ||
            burst_wdata !== 64'h0 || line_rdata !== 256'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h wdata=%h rdata_nonzero=%b, required all 0",
                     line_resp, burst_read, burst_write, burst_address, burst_wdata, |line_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            burst_resp = k[0];
            if (line_resp || burst_read || burst_write || burst_address !== 32'h0) bad++;
        end
        burst_resp = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL idle_quiet: got %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_write();
        logic [255:0] wdata, wr_line, rd;
        int nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post;
        bit to;
        wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_txn(1'b1, 1'b0, 32'h0000_1234, wdata, '0, 0, 1'b0,
               wr_line, nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post, rd, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL write_timeout: got no line_resp, required one"); end
        checks++;
        if (addr_bad !== 0) begin errors++; $display("[TB] FAIL write_addr: got %0d beats off 00001220, required 0", addr_bad); end
        checks++;
        if (wr_line !== wdata || nw !== 4 || nr !== 0) begin
            errors++;
            $display("[TB] FAIL write_beats: got nw=%0d nr=%0d line=%h, required nw=4 nr=0 line=%h", nw, nr, wr_line, wdata);
        end
        checks++;
        if (resps !== 1 || cycles !== 6) begin
            errors++;
            $display("[TB] FAIL write_latency: got resps=%0d cycle=%0d, required 1 at cycle 6", resps, cycles);
        end
        checks++;
        if (post !== 0) begin errors++; $display("[TB] FAIL write_post: got %0d extra active cycles, required 0", post); end
    endtask

    task automatic test_read_gaps();
        logic [255:0] rline, wr_line, got;
        int nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post;
        bit to;
        rline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_txn(1'b0, 1'b1, 32'h8000_00FF, '0, rline, 1, 1'b0,
               wr_line, nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post, got, to);
        checks++;
        if (to || resps !== 1) begin errors++; $display("[TB] FAIL read_resp: got %0d responses, required 1", resps); end
        checks++;
        if (addr_bad !== 0) begin errors++; $display("[TB] FAIL read_addr: got %0d beats off 800000E0, required 0", addr_bad); end
        checks++;
        if (got !== rline) begin errors++; $display("[TB] FAIL read_data: got %h, required %h", got, rline); end
        checks++;
        if (gap_drop !== 0 || nw !== 0 || nr !== 4) begin
            errors++;
            $display("[TB] FAIL read_hold: got drops=%0d nw=%0d nr=%0d, required 0/0/4", gap_drop, nw, nr);
        end
        checks++;
        if (cycles !== 12) begin errors++; $display("[TB] FAIL read_latency: got cycle %0d, required 12", cycles); end
        checks++;
        if (line_rdata !== rline) begin errors++; $display("[TB] FAIL read_retain: got %h, required %h", line_rdata, rline); end
    endtask

    task automatic test_simultaneous();
        logic [255:0] wdata, rline, wr_line, got;
        int nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post;
        bit to;
        wdata = rand_line();
        rline = rand_line();
        do_txn(1'b1, 1'b1, 32'h0000_4040, wdata, rline, 0, 1'b0,
               wr_line, nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post, got, to);
        checks++;
        if (to || resps !== 1 || nw !== 4 || nr !== 0 || wr_line !== wdata) begin
            errors++;
            $display("[TB] FAIL both_write_wins: got resps=%0d nw=%0d nr=%0d, required 1/4/0 with write data", resps, nw, nr);
        end
        checks++;
        if (post !== 0) begin errors++; $display("[TB] FAIL both_no_read: got %0d active cycles after resp, required 0", post); end
        do_txn(1'b0, 1'b1, 32'h0000_4040, '0, rline, 2, 1'b0,
               wr_line, nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post, got, to);
        checks++;
        if (to || resps !== 1 || got !== rline || nr !== 4) begin
            errors++;
            $display("[TB] FAIL both_reread: got resps=%0d nr=%0d data=%h, required 1/4/%h", resps, nr, got, rline);
        end
    endtask

    task automatic test_reset_midburst();
        logic [255:0] rline, wr_line, got;
        int nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post;
        int given, bad;
        bit to;
        rline = rand_line();
        given = 0;
        @(negedge clk);
        line_address = 32'h0000_0A00;
        line_read    = 1'b1;
        for (int k = 0; k < 50 && given < 2; k++) begin
            @(negedge clk);
            burst_resp = 1'b0;
            if (burst_read) begin
                burst_resp  = 1'b1;
                burst_rdata = rline[64*given +: 64];
                given++;
            end
        end
        @(negedge clk);
        burst_resp = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (burst_read !== 1'b0 || burst_address !== 32'h0 || line_resp !== 1'b0 || line_rdata !== 256'h0) begin
            errors++;
            $display("[TB] FAIL midburst_reset: got rd=%b addr=%h resp=%b rdata_nonzero=%b, required all 0",
                     burst_read, burst_address, line_resp, |line_rdata);
        end
        line_read = 1'b0;
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (line_resp || burst_read) bad++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (line_resp || burst_read || burst_write) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL midburst_silent: got %0d active cycles, required 0", bad); end
        rline = rand_line();
        do_txn(1'b0, 1'b1, 32'h0000_0A00, '0, rline, 2, 1'b0,
               wr_line, nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post, got, to);
        checks++;
        if (to || resps !== 1 || got !== rline || cycles !== 6 + stalls) begin
            errors++;
            $display("[TB] FAIL midburst_fresh_read: got resps=%0d cycle=%0d data=%h, required 1 at %0d with %h",
                     resps, cycles, got, 6 + stalls, rline);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] wdata, rline, wr_line, got;
        int nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post;
        bit to;
        wdata = rand_line();
        rline = rand_line();
        do_txn(1'b1, 1'b0, 32'h1234_5678, wdata, '0, 0, 1'b1,
               wr_line, nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post, got, to);
        checks++;
        if (to || resps !== 1 || nw !== 4 || post !== 0 || wr_line !== wdata) begin
            errors++;
            $display("[TB] FAIL b2b_write: got resps=%0d nw=%0d extra=%0d, required 1/4/0", resps, nw, post);
        end
        do_txn(1'b0, 1'b1, 32'h8765_4321, '0, rline, 0, 1'b1,
               wr_line, nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post, got, to);
        checks++;
        if (to || resps !== 1 || nr !== 4 || post !== 0 || got !== rline || addr_bad !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_read: got resps=%0d nr=%0d extra=%0d addr_bad=%0d, required 1/4/0/0",
                     resps, nr, post, addr_bad);
        end
    endtask

    task automatic test_random();
        logic [255:0] wdata, rline, wr_line, got, last_rd;
        logic [31:0]  addr;
        int nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post;
        bit to, is_wr;
        last_rd = '0;
        for (int i = 0; i < 14; i++) begin
            is_wr = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = rand_line();
            rline = rand_line();
            do_txn(is_wr, !is_wr, addr, wdata, rline, 2, 1'($urandom_range(0, 1)),
                   wr_line, nw, nr, resps, cycles, stalls, addr_bad, gap_drop, post, got, to);
            checks++;
            if (to || resps !== 1 || post !== 0 || addr_bad !== 0 || gap_drop !== 0 ||
                cycles !== 6 + stalls) begin
                errors++;
                $display("[TB] FAIL rand_txn%0d: got resps=%0d extra=%0d addr_bad=%0d drops=%0d cycle=%0d, required 1/0/0/0/%0d",
                         i, resps, post, addr_bad, gap_drop, cycles, 6 + stalls);
            end
            checks++;
            if (is_wr) begin
                if (nw !== 4 || nr !== 0 || wr_line !== wdata || got !== last_rd) begin
                    errors++;
                    $display("[TB] FAIL rand_write%0d: got nw=%0d nr=%0d line=%h rdata=%h, required 4/0 line=%h rdata=%h",
                             i, nw, nr, wr_line, got, wdata, last_rd);
                end
            end else begin
                if (nr !== 4 || nw !== 0 || got !== rline) begin
                    errors++;
                    $display("[TB] FAIL rand_read%0d: got nr=%0d nw=%0d data=%h, required 4/0 data=%h",
                             i, nr, nw, got, rline);
                end
                last_rd = rline;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_gaps();
        test_simultaneous();
        test_reset_midburst();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
